// File: rtl/motor_motion_sequencer_pkg.sv
// Shared state encoding, duty limits and duty helpers for the motion sequencer and motor_driver.
// Duty is 0..100 where 100 means stopped, so "slower" is numerically larger.
package motor_motion_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_HOLD     = 3'd2,
        ST_STOPRAMP = 3'd3,
        ST_ESTOP    = 3'd4
    } state_t;

    localparam logic [7:0] DUTY_STOP = 8'd100;
    localparam logic [7:0] DUTY_MAX  = 8'd100;

    function automatic logic [7:0] clamp_duty(input logic [7:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (tgt > cur)
            return cur + 8'd1;
        else if (tgt < cur)
            return cur - 8'd1;
        else
            return cur;
    endfunction

endpackage

// File: rtl/motor_motion_sequencer_ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, first tick TICK_DIV clocks after reset.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic n_rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/motor_motion_sequencer.sv
// Timed speed-command sequencer for motor_driver: ramp to target, hold, ramp back to stop.
// estop overrides everything and forces the motor stopped on the next edge.
module motor_motion_sequencer
    import motor_motion_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int RAMP_TICKS = 5,
    parameter int MS_W       = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [7:0]      cmd_duty,
    input  logic [MS_W-1:0] cmd_ms,
    input  logic            estop,
    output logic [7:0]      duty_cycle,
    output logic            motor_en,
    output logic            busy,
    output logic            done
);

    localparam int RW = $clog2(RAMP_TICKS + 1);

    state_t          state, state_n;
    logic [7:0]      duty, duty_n;
    logic [7:0]      target, target_n;
    logic [MS_W-1:0] ms_lat, ms_n;
    logic [MS_W-1:0] hold_cnt, hold_n;
    logic [RW-1:0]   ramp_cnt, ramp_n;
    logic            en, en_n;
    logic            done_q, done_n;
    logic            tick;
    logic            ramp_step;
    logic            accept;
    logic [7:0]      stepped;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .n_rst (n_rst),
        .tick  (tick)
    );

    assign cmd_ready  = (state == ST_IDLE) || (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);
    assign duty_cycle = duty;
    assign motor_en   = en;
    assign done       = done_q;
    assign accept     = cmd_valid && cmd_ready;
    assign ramp_step  = tick && (ramp_cnt == RW'(RAMP_TICKS - 1));
    assign stepped    = step_toward(duty, target);

    always_comb begin
        state_n  = state;
        duty_n   = duty;
        target_n = target;
        ms_n     = ms_lat;
        hold_n   = hold_cnt;
        done_n   = 1'b0;

        if (estop) begin
            state_n = ST_ESTOP;
            duty_n  = DUTY_STOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    duty_n = DUTY_STOP;
                    if (accept) begin
                        target_n = clamp_duty(cmd_duty);
                        ms_n     = cmd_ms;
                        state_n  = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Already at target: no tick wait before holding.
                    if (duty == target) begin
                        state_n = ST_HOLD;
                        hold_n  = ms_lat;
                    end else if (ramp_step) begin
                        duty_n = stepped;
                        if (stepped == target) begin
                            state_n = ST_HOLD;
                            hold_n  = ms_lat;
                        end
                    end
                end
                ST_HOLD: begin
                    // A new command takes priority over expiry of the current hold.
                    if (accept) begin
                        target_n = clamp_duty(cmd_duty);
                        ms_n     = cmd_ms;
                        state_n  = ST_RAMP;
                    end else if ((ms_lat != '0) && tick) begin
                        if (hold_cnt <= MS_W'(1)) begin
                            hold_n  = '0;
                            state_n = ST_STOPRAMP;
                        end else begin
                            hold_n = hold_cnt - 1'b1;
                        end
                    end
                end
                ST_STOPRAMP: begin
                    if (duty >= DUTY_STOP) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else if (ramp_step) begin
                        duty_n = duty + 8'd1;
                        if (duty + 8'd1 == DUTY_STOP) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_ESTOP: begin
                    state_n = ST_IDLE;
                    duty_n  = DUTY_STOP;
                end
                default: begin
                    state_n = ST_IDLE;
                    duty_n  = DUTY_STOP;
                end
            endcase
        end

        // Restart the step interval on every state change so each ramp gets a full first step.
        if ((state_n != state) || !((state == ST_RAMP) || (state == ST_STOPRAMP)))
            ramp_n = '0;
        else if (ramp_step)
            ramp_n = '0;
        else if (tick)
            ramp_n = ramp_cnt + 1'b1;
        else
            ramp_n = ramp_cnt;

        en_n = (state_n == ST_RAMP) || (state_n == ST_HOLD) || (state_n == ST_STOPRAMP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            duty     <= DUTY_STOP;
            target   <= DUTY_STOP;
            ms_lat   <= '0;
            hold_cnt <= '0;
            ramp_cnt <= '0;
            en       <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            target   <= target_n;
            ms_lat   <= ms_n;
            hold_cnt <= hold_n;
            ramp_cnt <= ramp_n;
            en       <= en_n;
            done_q   <= done_n;
        end
    end

endmodule
